// File: rtl/logic_unit_pkg.sv
// Shared opcode constants and arbiter state encoding for the logic unit slice.
package logic_unit_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOTA = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/logic_unit.sv
// Combinational bitwise logic unit; the reserved opcode returns zero and flags err.
module logic_unit
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y,
    output logic             err
);

    // Opcode decode to bitwise result
    always_comb begin
        y   = {WIDTH{1'b0}};
        err = 1'b0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NOTA: y = ~a;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_RSVD: begin
                y   = {WIDTH{1'b0}};
                err = 1'b1;
            end
            default: begin
                y   = {WIDTH{1'b0}};
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin front end for a shared logic unit with a single
// registered result slot and ready/valid backpressure on the output.
module logic_unit_arbiter
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [2:0]       op0,
    input  logic [2:0]       op1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_id,
    output logic             out_err
);

    state_t           state_r;
    logic             last_grant_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic             out_id_r;
    logic             out_err_r;

    logic             accept_slot_s;
    logic             grant_any_s;
    logic             pick_s;
    logic [WIDTH-1:0] mux_a_s;
    logic [WIDTH-1:0] mux_b_s;
    logic [2:0]       mux_op_s;
    logic [WIDTH-1:0] lu_y_s;
    logic             lu_err_s;

    // Grant selection: a tie goes to the requester not granted last time
    always_comb begin
        accept_slot_s = (state_r == ST_IDLE) || out_ready;
        if (req0 && req1) begin
            pick_s = ~last_grant_r;
        end else begin
            pick_s = req1;
        end
        grant_any_s = accept_slot_s && (req0 || req1) && !rst;
    end

    // Operand mux feeding the single shared logic unit
    always_comb begin
        if (pick_s) begin
            mux_a_s  = a1;
            mux_b_s  = b1;
            mux_op_s = op1;
        end else begin
            mux_a_s  = a0;
            mux_b_s  = b0;
            mux_op_s = op0;
        end
    end

    logic_unit #(.WIDTH(WIDTH)) u_logic_unit (
        .a   (mux_a_s),
        .b   (mux_b_s),
        .op  (mux_op_s),
        .y   (lu_y_s),
        .err (lu_err_s)
    );

    // Result-slot FSM; the result fields keep their value when the slot drains
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b1;
            out_valid_r  <= 1'b0;
            out_data_r   <= {WIDTH{1'b0}};
            out_id_r     <= 1'b0;
            out_err_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_any_s) begin
                        state_r      <= ST_HOLD;
                        out_valid_r  <= 1'b1;
                        out_data_r   <= lu_y_s;
                        out_id_r     <= pick_s;
                        out_err_r    <= lu_err_s;
                        last_grant_r <= pick_s;
                    end else begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (grant_any_s) begin
                        state_r      <= ST_HOLD;
                        out_valid_r  <= 1'b1;
                        out_data_r   <= lu_y_s;
                        out_id_r     <= pick_s;
                        out_err_r    <= lu_err_s;
                        last_grant_r <= pick_s;
                    end else if (out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r     <= ST_HOLD;
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign gnt0      = grant_any_s && !pick_s;
    assign gnt1      = grant_any_s && pick_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_id    = out_id_r;
    assign out_err   = out_err_r;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed and randomized checks of logic_unit_arbiter against a behavioural model.
module tb_logic_unit_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] a0 = 8'h00, b0 = 8'h00, a1 = 8'h00, b1 = 8'h00;
    logic [2:0] op0 = 3'd0, op1 = 3'd0;
    logic       gnt0, gnt1, out_valid, out_id, out_err;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;

    int checks = 0;
    int errors = 0;

    logic_unit_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .op0(op0), .op1(op1),
        .gnt0(gnt0), .gnt1(gnt1),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_id(out_id), .out_err(out_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_op(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
        logic [7:0] r;
        case (op)
            3'd0:    r = a & b;
            3'd1:    r = a | b;
            3'd2:    r = 8'hFF - a;
            3'd3:    r = 8'hFF - (a & b);
            3'd4:    r = 8'hFF - (a | b);
            3'd5:    r = (a | b) & ~(a & b);
            3'd6:    r = 8'hFF - ((a | b) & ~(a & b));
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_id !== 1'b0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got v=%b d=%h id=%b e=%b want 0 00 0 0", out_valid, out_data, out_id, out_err);
        end
        req0 = 1'b1; a0 = 8'hFF; b0 = 8'h00; op0 = 3'd1;
        @(posedge clk); #1;
        req0 = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hFF) begin
            errors++;
            $display("FAIL reset_hold_setup got v=%b d=%h want 1 ff", out_valid, out_data);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_id !== 1'b0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_hold got v=%b d=%h id=%b e=%b want 0 00 0 0", out_valid, out_data, out_id, out_err);
        end
        req0 = 1'b1; req1 = 1'b1; out_ready = 1'b1;
        a1 = 8'h0F; b1 = 8'h0F; op1 = 3'd0;
        #1;
        checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_gnt_low got %b%b want 00", gnt0, gnt1);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_tie got %b%b want 10", gnt0, gnt1);
        end
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req0 = 1'b1; a0 = 8'hF0; b0 = 8'h3C; op0 = 3'd5;
        @(negedge clk);
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL single_gnt got %b%b want 10", gnt0, gnt1);
        end
        @(posedge clk); #1;
        req0 = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hCC || out_id !== 1'b0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL single_result got v=%b d=%h id=%b e=%b want 1 cc 0 0", out_valid, out_data, out_id, out_err);
        end
        @(negedge clk);
        checks++;
        if (gnt0 !== 1'b0) begin
            errors++;
            $display("FAIL single_gnt_once got %b want 0", gnt0);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] want_d;
        do_reset();
        req0 = 1'b1; a0 = 8'h11; b0 = 8'h22; op0 = 3'd1;
        req1 = 1'b1; a1 = 8'hF0; b1 = 8'hFF; op1 = 3'd0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (gnt0 !== ((i % 2) == 0) || gnt1 !== ((i % 2) == 1)) begin
                errors++;
                $display("FAIL rr_gnt[%0d] got %b%b want %b%b", i, gnt0, gnt1, (i % 2) == 0, (i % 2) == 1);
            end
            @(posedge clk); #1;
            want_d = ((i % 2) == 0) ? 8'h33 : 8'hF0;
            checks++;
            if (out_valid !== 1'b1 || out_id !== 1'(i % 2) || out_data !== want_d) begin
                errors++;
                $display("FAIL rr_out[%0d] got v=%b id=%b d=%h want 1 %0d %h", i, out_valid, out_id, out_data, i % 2, want_d);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        req0 = 1'b1; a0 = 8'h12; b0 = 8'h34; op0 = 3'd0;
        @(posedge clk); #1;
        req0 = 1'b0;
        req1 = 1'b1; a1 = 8'h55; b1 = 8'h00; op1 = 3'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
                errors++;
                $display("FAIL bp_gnt[%0d] got %b%b want 00", i, gnt0, gnt1);
            end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h10 || out_id !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d] got v=%b d=%h id=%b want 1 10 0", i, out_valid, out_data, out_id);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
            errors++;
            $display("FAIL bp_release_gnt got %b%b want 01", gnt0, gnt1);
        end
        @(posedge clk); #1;
        req1 = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hAA || out_id !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_out got v=%b d=%h id=%b want 1 aa 1", out_valid, out_data, out_id);
        end
    endtask

    task automatic test_opcodes();
        logic [7:0] tbl [8];
        tbl[0] = 8'h05; tbl[1] = 8'hAF; tbl[2] = 8'h5A; tbl[3] = 8'hFA;
        tbl[4] = 8'h50; tbl[5] = 8'hAA; tbl[6] = 8'h55; tbl[7] = 8'h00;
        do_reset();
        out_ready = 1'b1;
        req0 = 1'b1; a0 = 8'hA5; b0 = 8'h0F;
        for (int i = 0; i < 8; i++) begin
            op0 = 3'(i);
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== tbl[i] || out_err !== (i == 7)) begin
                errors++;
                $display("FAIL opcode[%0d] got v=%b d=%h e=%b want 1 %h %b", i, out_valid, out_data, out_err, tbl[i], i == 7);
            end
        end
        req0 = 1'b0;
    endtask

    task automatic test_drain();
        do_reset();
        out_ready = 1'b1;
        req0 = 1'b1; a0 = 8'hF0; b0 = 8'h3C; op0 = 3'd5;
        @(posedge clk); #1;
        req0 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'hCC || out_id !== 1'b0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL drain got v=%b d=%h id=%b e=%b want 0 cc 0 0", out_valid, out_data, out_id, out_err);
        end
    endtask

    task automatic test_random();
        // model: one result slot, pending requests per requester, tie memory
        logic       m_valid = 1'b0, m_id = 1'b0, m_err = 1'b0, m_last = 1'b1;
        logic [7:0] m_data = 8'h00;
        logic       pend [2];
        logic [7:0] ra [2];
        logic [7:0] rb [2];
        logic [2:0] ro [2];
        logic       slot, any, win;
        do_reset();
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(2) != 0) begin
                    pend[r] = 1'b1;
                    ra[r] = 8'($urandom_range(255));
                    rb[r] = 8'($urandom_range(255));
                    ro[r] = 3'($urandom_range(7));
                end
            end
            req0 = pend[0]; a0 = ra[0]; b0 = rb[0]; op0 = ro[0];
            req1 = pend[1]; a1 = ra[1]; b1 = rb[1]; op1 = ro[1];
            out_ready = ($urandom_range(3) != 0);
            slot = !m_valid || out_ready;
            any  = slot && (pend[0] || pend[1]);
            win  = (pend[0] && pend[1]) ? (m_last == 1'b1 ? 1'b0 : 1'b1) : pend[1];
            @(negedge clk);
            checks++;
            if (gnt0 !== (any && !win) || gnt1 !== (any && win)) begin
                errors++;
                $display("FAIL rand_gnt[%0d] got %b%b want %b%b", c, gnt0, gnt1, any && !win, any && win);
            end
            @(posedge clk); #1;
            if (any) begin
                m_valid = 1'b1;
                m_data  = ref_op(ra[win], rb[win], ro[win]);
                m_err   = (ro[win] == 3'd7);
                m_id    = win;
                m_last  = win;
                pend[win] = 1'b0;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            checks++;
            if (out_valid !== m_valid || out_data !== m_data || out_id !== m_id || out_err !== m_err) begin
                errors++;
                $display("FAIL rand_out[%0d] got v=%b d=%h id=%b e=%b want %b %h %b %b", c,
                         out_valid, out_data, out_id, out_err, m_valid, m_data, m_id, m_err);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_opcodes();
        test_drain();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
